// File: rtl/step_ctrl_pkg.sv
// Shared types and defaults for the execution-pacing controller (step_ctrl).
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'd0,
    MODE_STEP = 2'd1,
    MODE_AUTO = 2'd2,
    MODE_RUN  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_HALT  = 3'd0,
    ST_STEP  = 3'd1,
    ST_AUTO  = 3'd2,
    ST_RUN   = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  localparam int unsigned STEP_DEFAULT_DIV     = 125_000_000;
  localparam int unsigned STEP_DEBOUNCE_CYCLES = 1_000_000;

  // The four operating modes share their encoding with the first four states.
  function automatic state_e mode_to_state(input mode_e mode);
    return state_e'({1'b0, mode});
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debouncer and a
// one-cycle pulse on every accepted rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = step_ctrl_pkg::STEP_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned    CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours (the synchronizer depends on it).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      rise_o  <= 1'b0;
      // cnt_q counts consecutive cycles in which the synchronized input disagrees.
      if (sync2_q == level_o) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        level_o <= sync2_q;
        rise_o  <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/step_ctrl.sv
// Clock-enable pacing for the core: HALT / STEP / AUTO / RUN (+ BREAK when
// STEP_CTRL_BREAKPOINT_EN is defined). Everything runs on clk_i.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned DEFAULT_DIV     = STEP_DEFAULT_DIV,
  parameter int unsigned DEBOUNCE_CYCLES = STEP_DEBOUNCE_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_load_i,
  input  logic             step_btn_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      bp_pc_i,
  input  logic             bp_valid_i,
  output logic             cpu_en_o,
  output logic             tick_led_o,
  output logic [2:0]       state_o,
  output logic [31:0]      step_cnt_o,
  output logic             halted_o
);

  state_e           state_q, state_d;
  mode_e            mode;
  logic [CNT_W-1:0] div_q, auto_cnt_q, div_last;
  logic [31:0]      step_cnt_q;
  logic             pulse, bp_hit, btn_rise, unused_btn_level;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (step_btn_i),
    .level_o (unused_btn_level),
    .rise_o  (btn_rise)
  );

  assign mode = mode_e'(mode_i);
  // A period of zero behaves as a period of one.
  assign div_last = (div_q == '0) ? '0 : div_q - CNT_W'(1);

`ifdef STEP_CTRL_BREAKPOINT_EN
  logic bp_mask_q;

  assign bp_hit = bp_valid_i && (pc_i == bp_pc_i) && !bp_mask_q &&
                  (state_q inside {ST_STEP, ST_AUTO, ST_RUN});

  // Masking lets the core step past the address it just broke on.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                        bp_mask_q <= 1'b0;
    else if (state_q == ST_BREAK && state_d == ST_HALT) bp_mask_q <= 1'b1;
    else if (pulse)                                     bp_mask_q <= 1'b0;
  end
`else
  logic unused_bp;
  assign unused_bp = ^{pc_i, bp_pc_i, bp_valid_i};
  assign bp_hit    = 1'b0;
`endif

  // NOTE: both outputs get a default first so no path through the case
  // leaves them unassigned (which would infer a latch).
  always_comb begin
    state_d = mode_to_state(mode);
    pulse   = 1'b0;
    unique case (state_q)
      ST_RUN:   pulse = 1'b1;
      ST_STEP:  pulse = btn_rise;
      ST_AUTO:  pulse = !div_load_i && (auto_cnt_q >= div_last);
      ST_BREAK: state_d = (mode == MODE_HALT) ? ST_HALT : ST_BREAK;
      default:  ;
    endcase
    if (bp_hit) begin
      pulse   = 1'b0;
      state_d = ST_BREAK;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_HALT;
      cpu_en_o   <= 1'b0;
      tick_led_o <= 1'b0;
      step_cnt_q <= '0;
      div_q      <= CNT_W'(DEFAULT_DIV);
      auto_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cpu_en_o   <= pulse;
      tick_led_o <= tick_led_o ^ pulse;
      step_cnt_q <= step_cnt_q + 32'(pulse);
      // Outside AUTO the counter idles at zero, so entering AUTO starts a fresh period.
      if (div_load_i) begin
        div_q      <= div_i;
        auto_cnt_q <= '0;
      end else if (state_q != ST_AUTO || auto_cnt_q >= div_last) begin
        auto_cnt_q <= '0;
      end else begin
        auto_cnt_q <= auto_cnt_q + CNT_W'(1);
      end
    end
  end

  assign state_o    = state_q;
  assign step_cnt_o = step_cnt_q;
  assign halted_o   = (state_q == ST_HALT) || (state_q == ST_BREAK);

endmodule

// File: tb/tb_step_ctrl.sv
// Self-checking bench for step_ctrl: behavioural model compared every cycle
// plus directed literal checks.
module tb_step_ctrl;

  localparam int unsigned DEB     = 8;
  localparam int unsigned DEF_DIV = 125_000_000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] div = '0;
  logic        div_load = 1'b0;
  logic        btn = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] bp_pc = '0;
  logic        bp_valid = 1'b0;

  logic        cpu_en, tick_led, halted;
  logic [2:0]  state;
  logic [31:0] step_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  step_ctrl #(.CNT_W(32), .DEFAULT_DIV(DEF_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .mode_i     (mode),
    .div_i      (div),
    .div_load_i (div_load),
    .step_btn_i (btn),
    .pc_i       (pc),
    .bp_pc_i    (bp_pc),
    .bp_valid_i (bp_valid),
    .cpu_en_o   (cpu_en),
    .tick_led_o (tick_led),
    .state_o    (state),
    .step_cnt_o (step_cnt),
    .halted_o   (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [2:0]          m_state;
  bit                m_en, m_led, m_level, m_rise;
  logic [31:0]       m_cnt, m_div;
  longint unsigned   m_age;
  bit                raw_q[$];
  bit                syn_q[$];
`ifdef STEP_CTRL_BREAKPOINT_EN
  bit                m_mask;
`endif
  bit                syn, flip, p;
  bit [2:0]          nxt;
  longint unsigned   d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 3'd0; m_en = 1'b0; m_led = 1'b0; m_cnt = '0;
      m_div = DEF_DIV; m_age = 0; m_level = 1'b0; m_rise = 1'b0;
      raw_q.delete(); syn_q.delete();
`ifdef STEP_CTRL_BREAKPOINT_EN
      m_mask = 1'b0;
`endif
    end else begin
      // Button as seen after two synchronizer stages.
      syn = (raw_q.size() == 2) ? raw_q[0] : 1'b0;
      raw_q.push_back(btn);
      if (raw_q.size() > 2) void'(raw_q.pop_front());
      syn_q.push_back(syn);
      if (syn_q.size() > DEB) void'(syn_q.pop_front());
      flip = (syn_q.size() == DEB);
      foreach (syn_q[i]) if (syn_q[i] == m_level) flip = 1'b0;

      p = 1'b0;
      case (m_state)
        3'd3: p = 1'b1;
        3'd1: p = m_rise;
        3'd2: if (!div_load) begin
                d = (m_div == 0) ? 1 : longint'(m_div);
                p = ((m_age % d) == d - 1);
              end
        default: ;
      endcase
      nxt = {1'b0, mode};
`ifdef STEP_CTRL_BREAKPOINT_EN
      if (m_state == 3'd4) nxt = (mode == 2'd0) ? 3'd0 : 3'd4;
      if ((m_state inside {3'd1, 3'd2, 3'd3}) && bp_valid && pc == bp_pc && !m_mask) begin
        p = 1'b0;
        nxt = 3'd4;
      end
      if (m_state == 3'd4 && mode == 2'd0) m_mask = 1'b1;
      else if (p) m_mask = 1'b0;
`endif
      if (div_load) begin
        m_age = 0;
        m_div = div;
      end else if (m_state == 3'd2) m_age++;
      else m_age = 0;
      m_rise = flip && !m_level;
      if (flip) m_level = !m_level;
      m_en = p;
      m_cnt = m_cnt + 32'(p);
      m_led = m_led ^ p;
      m_state = nxt;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("cpu_en", 32'(cpu_en), 32'(m_en));
      check("tick_led", 32'(tick_led), 32'(m_led));
      check("state", 32'(state), 32'(m_state));
      check("step_cnt", step_cnt, m_cnt);
      check("halted", 32'(halted), 32'((m_state == 3'd0) || (m_state == 3'd4)));
    end
  end

  // ---------------- directed stimulus ----------------
  int   pulses, toggles;
  logic led_prev;
  logic [31:0] cnt0;
  bit glitch [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 0};

  task automatic count_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pulses += int'(cpu_en);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_halted", 32'(halted), 1);
    check("rst_cnt", step_cnt, 0);
    check("rst_en", 32'(cpu_en), 0);
    check("rst_led", 32'(tick_led), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // RUN: first cycle only changes state, pulses from the second on.
    mode = 2'd3;
    @(negedge clk); check("run_1st", 32'(cpu_en), 0);
    @(negedge clk); check("run_2nd", 32'(cpu_en), 1);
    repeat (9) @(negedge clk);
    check("run_cnt10", step_cnt, 10);

    // AUTO with period 5: 10 toggles in 50 cycles.
    mode = 2'd2; div = 5; div_load = 1'b1;
    @(negedge clk); div_load = 1'b0;
    repeat (2) @(negedge clk);
    led_prev = tick_led; toggles = 0; pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tick_led != led_prev) toggles++;
      led_prev = tick_led;
      pulses += int'(cpu_en);
    end
    check("auto_toggles", toggles, 10);
    check("auto_pulses", pulses, 10);

    // Button edge accepted while in HALT is discarded, not queued.
    mode = 2'd0;
    repeat (3) @(negedge clk);
    pulses = 0; btn = 1'b1;
    count_cycles(20);
    mode = 2'd1;
    count_cycles(10);
    btn = 1'b0;
    count_cycles(20);
    check("halt_edge_drop", pulses, 0);

    // STEP with bouncing press then a long hold: exactly one pulse.
    cnt0 = step_cnt; pulses = 0;
    foreach (glitch[i]) begin
      btn = glitch[i];
      count_cycles(1);
    end
    btn = 1'b1;
    count_cycles(100);
    btn = 1'b0;
    count_cycles(20);
    check("step_one_pulse", pulses, 1);
    check("step_cnt_delta", step_cnt - cnt0, 1);

    // AUTO with period 0 pulses every cycle.
    mode = 2'd2; div = 0; div_load = 1'b1;
    @(negedge clk); div_load = 1'b0;
    pulses = 0;
    count_cycles(8);
    check("div0_pulses", pulses, 8);
    // Reload mid-period: no pulse on the load cycle, next pulse 3 cycles later.
    div = 7; div_load = 1'b1;
    @(negedge clk); div_load = 1'b0;
    repeat (3) @(negedge clk);
    div = 3; div_load = 1'b1;
    @(negedge clk); div_load = 1'b0;
    check("load_no_pulse", 32'(cpu_en), 0);
    @(negedge clk); check("load_p1", 32'(cpu_en), 0);
    @(negedge clk); check("load_p2", 32'(cpu_en), 0);
    @(negedge clk); check("load_p3", 32'(cpu_en), 1);

`ifdef STEP_CTRL_BREAKPOINT_EN
    mode = 2'd3; bp_pc = 32'h40; bp_valid = 1'b1; pc = 32'h3C;
    repeat (3) @(negedge clk);
    pc = 32'h40;
    @(negedge clk);
    check("bp_no_pulse", 32'(cpu_en), 0);
    check("bp_state", 32'(state), 4);
    check("bp_halted", 32'(halted), 1);
    repeat (3) @(negedge clk);
    check("bp_hold", 32'(state), 4);
    mode = 2'd0;
    @(negedge clk); check("bp_exit_halt", 32'(state), 0);
    mode = 2'd1;
    @(negedge clk); check("bp_to_step", 32'(state), 1);
    pulses = 0; btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pulses += int'(cpu_en);
      if (cpu_en) pc = 32'h44;
    end
    btn = 1'b0;
    count_cycles(15);
    check("bp_step_past", pulses, 1);
    bp_valid = 1'b0;
`else
    mode = 2'd3; bp_pc = 32'h40; bp_valid = 1'b1; pc = 32'h40;
    repeat (3) @(negedge clk);
    check("nobp_state", 32'(state), 3);
    check("nobp_en", 32'(cpu_en), 1);
    bp_valid = 1'b0;
`endif

    // Asynchronous reset while AUTO pulses every cycle.
    mode = 2'd2; div = 1; div_load = 1'b1;
    @(negedge clk); div_load = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_en", 32'(cpu_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_en", 32'(cpu_en), 0);
    check("arst_cnt", step_cnt, 0);
    check("arst_led", 32'(tick_led), 0);
    check("arst_halted", 32'(halted), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Pulse counter wraps from all-ones to zero.
    mode = 2'd3;
    @(negedge clk);
    #1;
    force dut.step_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.step_cnt_q;
    @(negedge clk);
    check("wrap_cnt", step_cnt, 0);
    check("wrap_en", 32'(cpu_en), 1);

    mode = 2'd0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
